// File: rtl/lsu_if.sv
// Request/response handshake bundle between the core memory stage and the load/store unit.
//   req_*  : request channel (valid/ready), store flag, funct3, byte address, store data
//   rsp_*  : response channel (valid/ready), load data, error flag
// Modports: master = core side, slave = load_store_unit side.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit between the core memory stage and a word-wide data memory
// (combinational read, synchronous write). Handles LB/LH/LW/LBU/LHU and SB/SH/SW,
// checks alignment, extracts/extends load data and does read-modify-write for SB/SH.
// One response per accepted request.
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   bus           lsu_if.slave: request/response handshake
//   mem_address   word address to data memory (from latched byte address)
//   mem_wr_en     write strobe, high only in the WRITE state
//   mem_wr_data   word to write (store data or merged word)
//   mem_rd_data   combinational read data from data memory
// Optional feature: define LSU_PERF_CNT_EN to add cnt_load/cnt_store/cnt_err,
// saturating 16-bit counters of completed responses by class.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lsu_if.slave                  bus,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_wr_en,
  output logic [31:0]           mem_wr_data,
  input  logic [31:0]           mem_rd_data
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [15:0]           cnt_load,
  output logic [15:0]           cnt_store,
  output logic [15:0]           cnt_err
`endif
);

  localparam int unsigned AQ_WIDTH = ADDR_WIDTH + 2;
  localparam int unsigned CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state, state_next;

  logic                we_q;
  logic [2:0]          funct3_q;
  logic [AQ_WIDTH-1:0] addr_q;
  logic [15:0]         wdata_lo_q;
  logic [31:0]         mem_wr_data_q;
  logic                rsp_valid_q;
  logic [31:0]         rsp_rdata_q;
  logic                rsp_err_q;
  logic                req_ready_c;
  logic                req_err_c;

  // Misalignment or unsupported funct3 for the given direction.
  function automatic logic access_error(input logic we, input logic [2:0] f3,
                                        input logic [1:0] lo);
    logic err;
    err = 1'b1;
    if (we) begin
      case (f3)
        3'd0:    err = 1'b0;
        3'd1:    err = lo[0];
        3'd2:    err = |lo;
        default: err = 1'b1;
      endcase
    end else begin
      case (f3)
        3'd0, 3'd4: err = 1'b0;
        3'd1, 3'd5: err = lo[0];
        3'd2:       err = |lo;
        default:    err = 1'b1;
      endcase
    end
    return err;
  endfunction

  // Select the addressed lane and sign/zero extend to 32 bits.
  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] lo,
                                          input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'd0:    r = {{24{b[7]}}, b};
      3'd4:    r = {24'd0, b};
      3'd1:    r = {{16{h[15]}}, h};
      3'd5:    r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed byte/half of the old word with the store data.
  function automatic logic [31:0] merge(input logic [2:0] f3, input logic [1:0] lo,
                                        input logic [31:0] old, input logic [15:0] wd);
    logic [31:0] r;
    r = old;
    if (f3 == 3'd0) begin
      r[{lo, 3'b000} +: 8] = wd[7:0];
    end else if (lo[1]) begin
      r[31:16] = wd;
    end else begin
      r[15:0] = wd;
    end
    return r;
  endfunction

  assign req_err_c = access_error(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and state-decoded strobes.
  always_comb begin
    state_next  = state;
    req_ready_c = 1'b0;
    mem_wr_en   = 1'b0;
    case (state)
      IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) begin
          if (req_err_c) begin
            state_next = RESP;
          end else if (bus.req_we && (bus.req_funct3 == 3'd2)) begin
            state_next = WRITE;
          end else begin
            state_next = READ;
          end
        end
      end
      READ:  state_next = we_q ? WRITE : RESP;
      WRITE: begin
        mem_wr_en  = 1'b1;
        state_next = RESP;
      end
      RESP:  if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture, load result and store word. For SB/SH the old word read in
  // READ is merged straight into the write-data register used in WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q          <= 1'b0;
      funct3_q      <= 3'd0;
      addr_q        <= '0;
      wdata_lo_q    <= 16'd0;
      mem_wr_data_q <= 32'd0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 32'd0;
      rsp_err_q     <= 1'b0;
    end else begin
      rsp_valid_q <= (state_next == RESP);
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q        <= bus.req_we;
            funct3_q    <= bus.req_funct3;
            addr_q      <= bus.req_addr[AQ_WIDTH-1:0];
            wdata_lo_q  <= bus.req_wdata[15:0];
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= req_err_c;
            if (bus.req_we && (bus.req_funct3 == 3'd2) && !req_err_c) begin
              mem_wr_data_q <= bus.req_wdata;
            end
          end
        end
        READ: begin
          if (we_q) begin
            mem_wr_data_q <= merge(funct3_q, addr_q[1:0], mem_rd_data, wdata_lo_q);
          end else begin
            rsp_rdata_q <= extract(funct3_q, addr_q[1:0], mem_rd_data);
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_address   = addr_q[AQ_WIDTH-1:2];
  assign mem_wr_data   = mem_wr_data_q;
  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

`ifdef LSU_PERF_CNT_EN
  logic rsp_done_c;
  assign rsp_done_c = rsp_valid_q && bus.rsp_ready;

  // Saturating per-class counters of completed responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_load  <= 16'd0;
      cnt_store <= 16'd0;
      cnt_err   <= 16'd0;
    end else if (rsp_done_c) begin
      if (rsp_err_q) begin
        if (cnt_err != 16'hFFFF) cnt_err <= cnt_err + CNT_WIDTH'(1);
      end else if (we_q) begin
        if (cnt_store != 16'hFFFF) cnt_store <= cnt_store + CNT_WIDTH'(1);
      end else begin
        if (cnt_load != 16'hFFFF) cnt_load <= cnt_load + CNT_WIDTH'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;
  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] mem_address;
  logic          mem_wr_en;
  logic [31:0]   mem_wr_data;
  logic [31:0]   mem_rd_data;
  logic [31:0]   mem [0:(1<<AW)-1];
  int            n_tests = 0;
  int            n_fail = 0;
  int            wr_cnt = 0;
  int            wr_before;
`ifdef LSU_PERF_CNT_EN
  logic [15:0]   cnt_load, cnt_store, cnt_err;
`endif

  lsu_if bus();

  load_store_unit #(.ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .mem_address (mem_address),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
`ifdef LSU_PERF_CNT_EN
    ,
    .cnt_load    (cnt_load),
    .cnt_store   (cnt_store),
    .cnt_err     (cnt_err)
`endif
  );

  always #5 clk = ~clk;

  assign mem_rd_data = mem[mem_address];

  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_address] <= mem_wr_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction: drive, wait for response (bounded), check, handshake.
  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    int lat;
    @(negedge clk);
    check({tag, "/req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.rsp_ready  = 1'b0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "/rdata"}, bus.rsp_rdata, exp_rd);
    check({tag, "/err"}, 32'(bus.rsp_err), 32'(exp_err));
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    check({tag, "/rsp_drop"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.rsp_ready  = 1'b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'd0;

    #12;
    check("rst/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst/rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst/rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst/mem_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst/mem_address", 32'(mem_address), 32'd0);
    check("rst/mem_wr_data", mem_wr_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store/load
    xact("sw_10", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 2);
    xact("lw_10", 1'b0, 3'd2, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 2);

    // Byte store with read-modify-write, byte loads
    xact("sb_13", 1'b1, 3'd0, 32'h13, 32'h000000A5, 32'd0, 1'b0, 3);
    xact("lw_10b", 1'b0, 3'd2, 32'h10, 32'd0, 32'hA5ADBEEF, 1'b0, 2);
    xact("lb_13", 1'b0, 3'd0, 32'h13, 32'd0, 32'hFFFFFFA5, 1'b0, 2);
    xact("lbu_13", 1'b0, 3'd4, 32'h13, 32'd0, 32'h000000A5, 1'b0, 2);

    // Half store, half loads, wrapped address
    xact("sh_12", 1'b1, 3'd1, 32'h12, 32'h00001234, 32'd0, 1'b0, 3);
    xact("lh_12", 1'b0, 3'd1, 32'h12, 32'd0, 32'h00001234, 1'b0, 2);
    xact("lh_10", 1'b0, 3'd1, 32'h10, 32'd0, 32'hFFFFBEEF, 1'b0, 2);
    xact("lhu_10", 1'b0, 3'd5, 32'h10, 32'd0, 32'h0000BEEF, 1'b0, 2);
    xact("lb_11", 1'b0, 3'd0, 32'h11, 32'd0, 32'hFFFFFFBE, 1'b0, 2);
    xact("lw_wrap", 1'b0, 3'd2, 32'h00001010, 32'd0, 32'h1234BEEF, 1'b0, 2);

    // Errors: no memory write, zero data, latency 1
    wr_before = wr_cnt;
    xact("err_lw_11", 1'b0, 3'd2, 32'h11, 32'd0, 32'd0, 1'b1, 1);
    xact("err_sh_13", 1'b1, 3'd1, 32'h13, 32'hFFFF, 32'd0, 1'b1, 1);
    xact("err_ld_f3", 1'b0, 3'd3, 32'h10, 32'd0, 32'd0, 1'b1, 1);
    xact("err_st_f3", 1'b1, 3'd3, 32'h10, 32'h0, 32'd0, 1'b1, 1);
    check("err/no_write", 32'(wr_cnt), 32'(wr_before));
    xact("err_chk_word", 1'b0, 3'd2, 32'h10, 32'd0, 32'h1234BEEF, 1'b0, 2);
`ifdef LSU_PERF_CNT_EN
    check("cnt/load", 32'(cnt_load), 32'd10);
    check("cnt/store", 32'(cnt_store), 32'd3);
    check("cnt/err", 32'(cnt_err), 32'd4);
`endif

    // Back-pressure: response held stable while rsp_ready low
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd2;
    bus.req_addr   = 32'h10;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      check("hold/rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold/rdata", bus.rsp_rdata, 32'h1234BEEF);
      check("hold/req_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    check("hold/rsp_drop", 32'(bus.rsp_valid), 32'd0);
    check("hold/idle_ready", 32'(bus.req_ready), 32'd1);

    // Reset during SB WRITE cycle aborts the write
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'h10;
    bus.req_wdata  = 32'h00000077;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("abort/wr_en_pre", 32'(mem_wr_en), 32'd1);
    check("abort/wr_data_pre", mem_wr_data, 32'h1234BE77);
    rst_n = 1'b0;
    #1;
    check("abort/wr_en", 32'(mem_wr_en), 32'd0);
    check("abort/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort/mem_address", 32'(mem_address), 32'd0);
    check("abort/mem_wr_data", mem_wr_data, 32'd0);
    check("abort/req_ready", 32'(bus.req_ready), 32'd1);
`ifdef LSU_PERF_CNT_EN
    check("abort/cnt_load", 32'(cnt_load), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    xact("abort_word", 1'b0, 3'd2, 32'h10, 32'd0, 32'h1234BEEF, 1'b0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
